// File: rtl/toy_bus_ack_arb2_pkg.sv
// Shared ToyBusAck definitions: field widths, the beat record, and source selectors.
// The arbiter and the merge top both import this package.
package toy_bus_ack_arb2_pkg;

   localparam int OPCODE_W = 1;
   localparam int DATA_W   = 32;
   localparam int ID_W     = 4;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [DATA_W-1:0]   data;
      logic [ID_W-1:0]     src_id;
      logic [ID_W-1:0]     tgt_id;
   } ack_beat_t;

   typedef enum logic {
      SRC_IN0 = 1'b0,
      SRC_IN1 = 1'b1
   } src_sel_e;

endpackage

// File: rtl/toy_bus_rr_arb2.sv
// Two-input arbiter: holds the round-robin pointer and derives both ready signals from can_load.
// With RR_EN=0, in0 always wins a tie and the pointer is ignored.
module toy_bus_rr_arb2
   import toy_bus_ack_arb2_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic in0_vld,
   input  logic in1_vld,
   input  logic can_load,
   output logic in0_rdy,
   output logic in1_rdy
);

   src_sel_e ptr;
   logic     prefer1;

   assign prefer1 = RR_EN ? (ptr == SRC_IN1) : 1'b0;

   // Neither ready looks at its own valid, so the upstream handshake stays free of loops.
   assign in0_rdy = can_load && !(in1_vld && prefer1);
   assign in1_rdy = can_load && !(in0_vld && !prefer1);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= SRC_IN0;
      end else if (in0_vld && in0_rdy) begin
         ptr <= SRC_IN1;
      end else if (in1_vld && in1_rdy) begin
         ptr <= SRC_IN0;
      end
   end

endmodule

// File: rtl/toy_bus_ack_arb2.sv
// Merges two ToyBusAck streams into one through a single-entry output register.
// The arbiter picks at most one source per cycle; the register drains and refills in the same cycle.
module toy_bus_ack_arb2
   import toy_bus_ack_arb2_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in0_vld,
   output logic                in0_rdy,
   input  logic [OPCODE_W-1:0] in0_opcode,
   input  logic [DATA_W-1:0]   in0_data,
   input  logic [ID_W-1:0]     in0_src_id,
   input  logic [ID_W-1:0]     in0_tgt_id,
   input  logic                in1_vld,
   output logic                in1_rdy,
   input  logic [OPCODE_W-1:0] in1_opcode,
   input  logic [DATA_W-1:0]   in1_data,
   input  logic [ID_W-1:0]     in1_src_id,
   input  logic [ID_W-1:0]     in1_tgt_id,
   output logic                out_vld,
   input  logic                out_rdy,
   output logic [OPCODE_W-1:0] out_opcode,
   output logic [DATA_W-1:0]   out_data,
   output logic [ID_W-1:0]     out_src_id,
   output logic [ID_W-1:0]     out_tgt_id
);

   ack_beat_t in0_beat;
   ack_beat_t in1_beat;
   ack_beat_t out_beat;
   logic      can_load;
   logic      accept0;
   logic      accept1;

   assign in0_beat = {in0_opcode, in0_data, in0_src_id, in0_tgt_id};
   assign in1_beat = {in1_opcode, in1_data, in1_src_id, in1_tgt_id};

   assign can_load = !out_vld || out_rdy;
   assign accept0  = in0_vld && in0_rdy;
   assign accept1  = in1_vld && in1_rdy;

   toy_bus_rr_arb2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .in0_vld  (in0_vld),
      .in1_vld  (in1_vld),
      .can_load (can_load),
      .in0_rdy  (in0_rdy),
      .in1_rdy  (in1_rdy)
   );

   // NOTE: the payload is reset as well as the valid, so the bus reads all-zero coming out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_beat <= '0;
      end else if (accept0) begin
         out_vld  <= 1'b1;
         out_beat <= in0_beat;
      end else if (accept1) begin
         out_vld  <= 1'b1;
         out_beat <= in1_beat;
      end else if (out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

   assign out_opcode = out_beat.opcode;
   assign out_data   = out_beat.data;
   assign out_src_id = out_beat.src_id;
   assign out_tgt_id = out_beat.tgt_id;

endmodule

// File: tb/tb_toy_bus_ack_arb2.sv
// Bench for toy_bus_ack_arb2: a round-robin and a fixed-priority instance share one stimulus.
// Directed scenarios use literal expectations; the random phase uses a last-winner queue model.
module tb_toy_bus_ack_arb2;

   logic        clk;
   logic        rst;
   logic        out_rdy;
   logic        in0_vld, in1_vld;
   logic        in0_opcode, in1_opcode;
   logic [31:0] in0_data, in1_data;
   logic [3:0]  in0_src_id, in1_src_id, in0_tgt_id, in1_tgt_id;

   // Index 0 = RR_EN=1 instance, index 1 = RR_EN=0 instance.
   logic        rdy0_o [2];
   logic        rdy1_o [2];
   logic        vld_o  [2];
   logic        opc_o  [2];
   logic [31:0] data_o [2];
   logic [3:0]  src_o  [2];
   logic [3:0]  tgt_o  [2];

   int n_cmp;
   int n_bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   toy_bus_ack_arb2 #(.RR_EN(1'b1)) dut_rr (
      .clk(clk), .rst(rst),
      .in0_vld(in0_vld), .in0_rdy(rdy0_o[0]), .in0_opcode(in0_opcode), .in0_data(in0_data),
      .in0_src_id(in0_src_id), .in0_tgt_id(in0_tgt_id),
      .in1_vld(in1_vld), .in1_rdy(rdy1_o[0]), .in1_opcode(in1_opcode), .in1_data(in1_data),
      .in1_src_id(in1_src_id), .in1_tgt_id(in1_tgt_id),
      .out_vld(vld_o[0]), .out_rdy(out_rdy), .out_opcode(opc_o[0]), .out_data(data_o[0]),
      .out_src_id(src_o[0]), .out_tgt_id(tgt_o[0])
   );

   toy_bus_ack_arb2 #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .in0_vld(in0_vld), .in0_rdy(rdy0_o[1]), .in0_opcode(in0_opcode), .in0_data(in0_data),
      .in0_src_id(in0_src_id), .in0_tgt_id(in0_tgt_id),
      .in1_vld(in1_vld), .in1_rdy(rdy1_o[1]), .in1_opcode(in1_opcode), .in1_data(in1_data),
      .in1_src_id(in1_src_id), .in1_tgt_id(in1_tgt_id),
      .out_vld(vld_o[1]), .out_rdy(out_rdy), .out_opcode(opc_o[1]), .out_data(data_o[1]),
      .out_src_id(src_o[1]), .out_tgt_id(tgt_o[1])
   );

   task automatic idle_inputs();
      in0_vld = 1'b0; in0_opcode = 1'b0; in0_data = '0; in0_src_id = '0; in0_tgt_id = '0;
      in1_vld = 1'b0; in1_opcode = 1'b0; in1_data = '0; in1_src_id = '0; in1_tgt_id = '0;
   endtask

   // Advance to one time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      out_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      out_rdy = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (vld_o[i] !== 1'b0 || data_o[i] !== 32'h0 || opc_o[i] !== 1'b0 ||
             src_o[i] !== 4'h0 || tgt_o[i] !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_state inst%0d: vld=%b data=%h opc=%b src=%h tgt=%h required all zero",
                     i, vld_o[i], data_o[i], opc_o[i], src_o[i], tgt_o[i]);
         end
         n_cmp++;
         if (rdy0_o[i] !== 1'b1 || rdy1_o[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rdy inst%0d: rdy0=%b rdy1=%b required 1 1", i, rdy0_o[i], rdy1_o[i]);
         end
      end
      // Beats offered while reset is held must vanish.
      in0_vld = 1'b1; in0_data = 32'hDEAD_0000;
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (vld_o[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_discard inst%0d: out_vld=%b required 0", i, vld_o[i]);
         end
      end
      idle_inputs();
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      in0_vld = 1'b1; in0_opcode = 1'b1; in0_data = 32'hA5A5_0001; in0_src_id = 4'h2; in0_tgt_id = 4'h1;
      out_rdy = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (rdy0_o[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_rdy inst%0d: in0_rdy=%b required 1", i, rdy0_o[i]);
         end
      end
      tick();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({vld_o[i], opc_o[i], data_o[i], src_o[i], tgt_o[i]} !== {1'b1, 1'b1, 32'hA5A5_0001, 4'h2, 4'h1}) begin
            n_bad++;
            $display("FAIL single_out inst%0d: vld=%b opc=%b data=%h src=%h tgt=%h required 1 1 a5a50001 2 1",
                     i, vld_o[i], opc_o[i], data_o[i], src_o[i], tgt_o[i]);
         end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (vld_o[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drain inst%0d: out_vld=%b required 0", i, vld_o[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_data;
      do_reset();
      out_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in0_vld = 1'b1; in0_data = 32'h0000_0100 + 32'(k); in0_src_id = 4'h0;
         in1_vld = 1'b1; in1_data = 32'h0000_0200 + 32'(k); in1_src_id = 4'h1;
         #1;
         n_cmp++;
         if (rdy1_o[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL fixed_in1_rdy beat%0d: in1_rdy=%b required 0", k, rdy1_o[1]);
         end
         tick();
         for (int i = 0; i < 2; i++) begin
            exp_data = (i == 0 && (k % 2) == 1) ? 32'h0000_0200 + 32'(k) : 32'h0000_0100 + 32'(k);
            n_cmp++;
            if (vld_o[i] !== 1'b1 || data_o[i] !== exp_data) begin
               n_bad++;
               $display("FAIL alternate inst%0d beat%0d: vld=%b data=%h required 1 %h",
                        i, k, vld_o[i], data_o[i], exp_data);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      in0_vld = 1'b1; in0_data = 32'hCAFE_0000; out_rdy = 1'b0;
      tick();
      in0_vld = 1'b0;
      in1_vld = 1'b1; in1_data = 32'h1234_5678;
      for (int k = 0; k < 3; k++) begin
         #1;
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (rdy0_o[i] !== 1'b0 || rdy1_o[i] !== 1'b0) begin
               n_bad++;
               $display("FAIL stall_rdy inst%0d cyc%0d: rdy0=%b rdy1=%b required 0 0", i, k, rdy0_o[i], rdy1_o[i]);
            end
         end
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (vld_o[i] !== 1'b1 || data_o[i] !== 32'hCAFE_0000) begin
               n_bad++;
               $display("FAIL stall_hold inst%0d cyc%0d: vld=%b data=%h required 1 cafe0000", i, k, vld_o[i], data_o[i]);
            end
         end
      end
      out_rdy = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (rdy1_o[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL release_rdy inst%0d: in1_rdy=%b required 1", i, rdy1_o[i]);
         end
      end
      tick();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (vld_o[i] !== 1'b1 || data_o[i] !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL release_out inst%0d: vld=%b data=%h required 1 12345678", i, vld_o[i], data_o[i]);
         end
      end
   endtask

   task automatic test_drain_fill();
      do_reset();
      in1_vld = 1'b1; in1_data = 32'hBEEF_0001; out_rdy = 1'b1;
      tick();
      in1_vld = 1'b0;
      in0_vld = 1'b1; in0_data = 32'h0000_00FF;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (vld_o[i] !== 1'b1 || rdy0_o[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_pre inst%0d: vld=%b in0_rdy=%b required 1 1", i, vld_o[i], rdy0_o[i]);
         end
      end
      tick();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (vld_o[i] !== 1'b1 || data_o[i] !== 32'h0000_00FF) begin
            n_bad++;
            $display("FAIL drain_fill inst%0d: vld=%b data=%h required 1 000000ff", i, vld_o[i], data_o[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in0_vld = 1'b1; in0_data = 32'h5555_0000; out_rdy = 1'b0;
      tick();
      idle_inputs();
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (vld_o[i] !== 1'b0 || data_o[i] !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset inst%0d: vld=%b data=%h required 0 00000000", i, vld_o[i], data_o[i]);
         end
      end
      tick();
      rst = 1'b0;
      out_rdy = 1'b1;
      in0_vld = 1'b1; in0_data = 32'h0000_AAAA;
      in1_vld = 1'b1; in1_data = 32'h0000_BBBB;
      #1;
      n_cmp++;
      if (rdy0_o[0] !== 1'b1 || rdy1_o[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_rdy: rdy0=%b rdy1=%b required 1 0", rdy0_o[0], rdy1_o[0]);
      end
      tick();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (vld_o[i] !== 1'b1 || data_o[i] !== 32'h0000_AAAA) begin
            n_bad++;
            $display("FAIL post_reset_grant inst%0d: vld=%b data=%h required 1 0000aaaa", i, vld_o[i], data_o[i]);
         end
      end
   endtask

   // Reference: a one-deep queue per instance plus the identity of the last granted source.
   task automatic test_random();
      logic [40:0] m_entry [2];
      logic        m_full  [2];
      int          last_win[2];
      logic [40:0] beat0, beat1, actual;
      logic        exp_r0, exp_r1, can, tie_to_1;
      int          granted;
      int          starve [2];

      do_reset();
      for (int i = 0; i < 2; i++) begin
         m_full[i] = 1'b0; m_entry[i] = '0; last_win[i] = 1; starve[i] = 0;
      end
      for (int c = 0; c < 500; c++) begin
         in0_vld = ($urandom_range(0, 9) < 7); in0_opcode = 1'($urandom_range(0, 1));
         in0_data = $urandom(); in0_src_id = 4'($urandom_range(0, 15)); in0_tgt_id = 4'($urandom_range(0, 15));
         in1_vld = ($urandom_range(0, 9) < 7); in1_opcode = 1'($urandom_range(0, 1));
         in1_data = $urandom(); in1_src_id = 4'($urandom_range(0, 15)); in1_tgt_id = 4'($urandom_range(0, 15));
         out_rdy = ($urandom_range(0, 9) < 7);
         beat0 = {in0_opcode, in0_data, in0_src_id, in0_tgt_id};
         beat1 = {in1_opcode, in1_data, in1_src_id, in1_tgt_id};
         #1;
         for (int i = 0; i < 2; i++) begin
            can      = !m_full[i] || out_rdy;
            tie_to_1 = (i == 0) && (last_win[i] == 0);
            exp_r0   = can && !(in1_vld && tie_to_1);
            exp_r1   = can && !(in0_vld && !tie_to_1);
            n_cmp++;
            if (rdy0_o[i] !== exp_r0 || rdy1_o[i] !== exp_r1) begin
               n_bad++;
               $display("FAIL rand_rdy inst%0d cyc%0d: rdy0=%b rdy1=%b required %b %b",
                        i, c, rdy0_o[i], rdy1_o[i], exp_r0, exp_r1);
            end
            granted = (in0_vld && exp_r0) ? 0 : ((in1_vld && exp_r1) ? 1 : -1);
            if (granted == 0) begin
               m_full[i] = 1'b1; m_entry[i] = beat0; last_win[i] = 0;
            end else if (granted == 1) begin
               m_full[i] = 1'b1; m_entry[i] = beat1; last_win[i] = 1;
            end else if (out_rdy) begin
               m_full[i] = 1'b0;
            end
            // Round-robin fairness: a source left waiting on a both-valid tie must not lose twice in a row.
            if (i == 0 && in0_vld && in1_vld && granted >= 0) begin
               starve[0] = (granted == 0) ? 0 : starve[0] + 1;
               starve[1] = (granted == 1) ? 0 : starve[1] + 1;
               n_cmp++;
               if (starve[0] > 1 || starve[1] > 1) begin
                  n_bad++;
                  $display("FAIL rand_fair cyc%0d: losses in0=%0d in1=%0d required <=1", c, starve[0], starve[1]);
               end
            end else if (i == 0 && granted >= 0) begin
               starve[0] = 0; starve[1] = 0;
            end
         end
         tick();
         for (int i = 0; i < 2; i++) begin
            actual = {opc_o[i], data_o[i], src_o[i], tgt_o[i]};
            n_cmp++;
            if (vld_o[i] !== m_full[i] || (m_full[i] && actual !== m_entry[i])) begin
               n_bad++;
               $display("FAIL rand_out inst%0d cyc%0d: vld=%b beat=%h required %b %h",
                        i, c, vld_o[i], actual, m_full[i], m_entry[i]);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      out_rdy = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_drain_fill();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/toy_bus_ack_arb2.md
TOY_BUS_ACK_ARB2 -- requirements
Module: toy_bus_ack_arb2

Interface
REQ-001 Parameter RR_EN, default 1, 1 = round-robin between inputs, 0 = fixed priority with in0 highest.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in0_vld  input  1  ToyBusAck request valid, source 0.
REQ-005 in0_rdy  output  1  source 0 beat accepted when in0_vld && in0_rdy.
REQ-006 in0_opcode/in0_data/in0_src_id/in0_tgt_id  input  1/32/4/4  source 0 ack payload.
REQ-007 in1_vld, in1_rdy, in1_opcode, in1_data, in1_src_id, in1_tgt_id  same directions and widths as in0_*, source 1.
REQ-008 out_vld  output  1  registered merged ack valid.
REQ-009 out_rdy  input  1  downstream ready.
REQ-010 out_opcode/out_data/out_src_id/out_tgt_id  output  1/32/4/4  registered payload of the granted beat.

Function
REQ-011 Block SHALL merge two ToyBusAck streams into one through a single-entry output register: latency 1 cycle, throughput 1 beat/cycle.
REQ-012 can_load = !out_vld || out_rdy; it SHALL be the only condition for any in*_rdy assertion.
REQ-013 prefer1 = RR_EN ? ptr : 0, where ptr is a 1-bit priority register.
REQ-014 in0_rdy SHALL equal can_load && !(in1_vld && prefer1); in1_rdy SHALL equal can_load && !(in0_vld && !prefer1); neither ready depends on its own vld.
REQ-015 At most one input SHALL be accepted per cycle; when both are valid and can_load=1, the preferred input is accepted and the other is stalled.
REQ-016 On acceptance of inX, out_vld SHALL be 1 and the out_* payload SHALL equal inX's payload bit-for-bit from the next cycle.
REQ-017 When out_vld && out_rdy and no input is accepted, out_vld SHALL clear next cycle; payload registers may hold their stale value.
REQ-018 While out_vld && !out_rdy, out_vld and all out_* payload SHALL be held stable.
REQ-019 Round-robin: on acceptance of in0, ptr <= 1; on acceptance of in1, ptr <= 0; with no acceptance ptr holds; with RR_EN=0 ptr is don't-care.
REQ-020 Simultaneous drain and fill (out_vld && out_rdy && accept) SHALL replace the entry with the new beat, with no bubble.
REQ-021 No payload field SHALL be inspected or altered; tgt_id/src_id pass unchanged (routing is done by the downstream decode node).
REQ-022 A stalled valid input SHALL be granted within 2 accepted beats when RR_EN=1 (starvation-free).

Reset
REQ-023 On rst assertion, asynchronously: out_vld=0, out_opcode=0, out_data=0, out_src_id=0, out_tgt_id=0, ptr=0.
REQ-024 During reset in0_rdy and in1_rdy SHALL equal can_load (1) combinationally; beats presented while rst=1 SHALL be discarded.
REQ-025 Reset mid-transfer SHALL drop the held beat; first post-reset grant with both valid goes to in0.

Structure
REQ-026 ToyBusAck field widths (opcode 1, data 32, src_id 4, tgt_id 4) SHALL come from the shared bus package, not local literals.
REQ-027 Arbitration logic (ptr, prefer, ready generation) SHALL reside in one sub-module toy_bus_rr_arb2; the output register stays in the top.
REQ-028 No other sub-modules; all sequential elements SHALL use clk and rst only.

Verification
REQ-029 Only in0_vld=1, data=0xA5A5_0001, tgt_id=1, out_rdy=1 -> in0_rdy=1, next cycle out_vld=1, out_data=0xA5A5_0001, out_tgt_id=1.
REQ-030 Both valid every cycle, out_rdy=1, RR_EN=1, from reset -> out sources alternate in0,in1,in0,in1 on 4 consecutive cycles, no bubbles.
REQ-031 Same as REQ-030 with RR_EN=0 -> all 4 outputs from in0, in1_rdy=0 throughout.
REQ-032 out held with out_rdy=0 for 3 cycles, in1_vld=1 data=0x1234_5678 -> in0_rdy=in1_rdy=0, out_* unchanged for 3 cycles; out_rdy=1 -> in1 accepted same cycle, out_data=0x1234_5678 next cycle.
REQ-033 Entry valid, out_rdy=1, in0_vld=1 data=0x0000_00FF same cycle -> out_vld stays 1, out_data=0x0000_00FF next cycle.
REQ-034 Assert rst while out_vld=1 and ptr=1 -> out_vld=0 immediately; after release both valid -> in0 granted first.
